// File: rtl/traffic_light.sv
// Single-road RED -> GREEN -> YELLOW sequencer with a pedestrian request that shortens green.
// Optional macro TRAFFIC_LIGHT_PASS_LATCH_EN remembers requests made outside green.
module traffic_light #(
  parameter int unsigned RED_TIME    = 10,
  parameter int unsigned GREEN_TIME  = 60,
  parameter int unsigned YELLOW_TIME = 5,
  parameter int unsigned PASS_TIME   = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pass_request,
  output logic [7:0] clock,
  output logic       red,
  output logic       yellow,
  output logic       green
);

  localparam logic [1:0] S_RED    = 2'd0;
  localparam logic [1:0] S_GREEN  = 2'd1;
  localparam logic [1:0] S_YELLOW = 2'd2;

  localparam logic [7:0] L_RED    = 8'(RED_TIME);
  localparam logic [7:0] L_GREEN  = 8'(GREEN_TIME);
  localparam logic [7:0] L_YELLOW = 8'(YELLOW_TIME);
  localparam logic [7:0] L_PASS   = 8'(PASS_TIME);

  logic [1:0] r_state;
  logic [7:0] r_clock;
  logic       r_red;
  logic       r_yellow;
  logic       r_green;

  logic [1:0] w_next_state;
  logic [7:0] w_next_clock;
  logic       w_last;

  assign w_last = (r_clock == 8'd1);

`ifdef TRAFFIC_LIGHT_PASS_LATCH_EN
  logic r_pass_pending;
  logic w_pending_next;
  logic w_green_short;

  // A request on the very edge that enters green is honoured directly.
  assign w_green_short = r_pass_pending | pass_request;

  always_comb begin
    w_pending_next = r_pass_pending;
    if (r_state != S_GREEN && pass_request)
      w_pending_next = 1'b1;
    if (r_state == S_RED && w_last)
      w_pending_next = 1'b0;
  end
`else
  logic w_green_short;
  assign w_green_short = 1'b0;
`endif

  // NOTE: defaults first so every path assigns every output -- no latch.
  always_comb begin
    w_next_state = r_state;
    w_next_clock = r_clock - 8'd1;
    case (r_state)
      S_RED: begin
        if (w_last) begin
          w_next_state = S_GREEN;
          w_next_clock = w_green_short ? L_PASS : L_GREEN;
        end
      end
      S_GREEN: begin
        // A held request stops re-applying once clock has reached PASS_TIME.
        if (pass_request && (r_clock > L_PASS)) begin
          w_next_clock = L_PASS;
        end else if (w_last) begin
          w_next_state = S_YELLOW;
          w_next_clock = L_YELLOW;
        end
      end
      S_YELLOW: begin
        if (w_last) begin
          w_next_state = S_RED;
          w_next_clock = L_RED;
        end
      end
      default: begin
        w_next_state = S_RED;
        w_next_clock = L_RED;
      end
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_RED;
      r_clock  <= L_RED;
      r_red    <= 1'b1;
      r_yellow <= 1'b0;
      r_green  <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_clock  <= w_next_clock;
      r_red    <= (w_next_state == S_RED);
      r_yellow <= (w_next_state == S_YELLOW);
      r_green  <= (w_next_state == S_GREEN);
    end
  end

`ifdef TRAFFIC_LIGHT_PASS_LATCH_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pass_pending <= 1'b0;
    else
      r_pass_pending <= w_pending_next;
  end
`endif

  assign clock  = r_clock;
  assign red    = r_red;
  assign yellow = r_yellow;
  assign green  = r_green;

endmodule

// File: tb/tb_traffic_light.sv
// Directed bench for traffic_light: a cycle model pushes expected {red,yellow,green,clock}
// words to a queue that is popped and compared one cycle later.
module tb_traffic_light;

  localparam int RED_T    = 10;
  localparam int GREEN_T  = 60;
  localparam int YELLOW_T = 5;
  localparam int PASS_T   = 10;

  logic       clk;
  logic       rst_n;
  logic       pass_request;
  logic [7:0] clock;
  logic       red;
  logic       yellow;
  logic       green;

  traffic_light #(
    .RED_TIME   (RED_T),
    .GREEN_TIME (GREEN_T),
    .YELLOW_TIME(YELLOW_T),
    .PASS_TIME  (PASS_T)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pass_request(pass_request),
    .clock       (clock),
    .red         (red),
    .yellow      (yellow),
    .green       (green)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_step = 0;

  logic [10:0] exp_q[$];
  logic [10:0] obs_word;
  assign obs_word = {red, yellow, green, clock};

  // Independent cycle model: phase 0=red, 1=green, 2=yellow.
  int m_phase;
  int m_left;
  bit m_pend;

  function automatic logic [10:0] model_word();
    logic [10:0] w;
    w[10]  = (m_phase == 0);
    w[9]   = (m_phase == 2);
    w[8]   = (m_phase == 1);
    w[7:0] = 8'(m_left);
    return w;
  endfunction

  function automatic logic [10:0] word(input bit r, input bit y, input bit g, input int c);
    logic [10:0] w;
    w = {r, y, g, 8'(c)};
    return w;
  endfunction

  task automatic model_update(input logic pr, input logic rn);
    if (!rn) begin
      m_phase = 0;
      m_left  = RED_T;
      m_pend  = 1'b0;
    end else begin
`ifdef TRAFFIC_LIGHT_PASS_LATCH_EN
      bit take;
      take = m_pend || (pr && m_phase == 0);
      if (pr && m_phase != 1) m_pend = 1'b1;
`endif
      if (m_phase == 1 && pr && m_left > PASS_T) begin
        m_left = PASS_T;
      end else if (m_left > 1) begin
        m_left = m_left - 1;
      end else if (m_phase == 0) begin
        m_phase = 1;
        m_left  = GREEN_T;
`ifdef TRAFFIC_LIGHT_PASS_LATCH_EN
        if (take) m_left = PASS_T;
        m_pend = 1'b0;
`endif
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_left  = YELLOW_T;
      end else begin
        m_phase = 0;
        m_left  = RED_T;
      end
    end
  endtask

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, predict, then compare 1 ns after the rising edge.
  task automatic step(input logic pr, input logic rn);
    logic [10:0] e;
    @(negedge clk);
    pass_request = pr;
    rst_n        = rn;
    model_update(pr, rn);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    n_step++;
    e = exp_q.pop_front();
    check($sformatf("step%0d", n_step), obs_word, e);
  endtask

  task automatic steps(input int n, input logic pr);
    for (int i = 0; i < n; i++) step(pr, 1'b1);
  endtask

  task automatic run_until(input int phase, input int left, input int max_n);
    logic reached;
    reached = 1'b0;
    for (int i = 0; i < max_n; i++) begin
      if (m_phase == phase && m_left == left) begin
        reached = 1'b1;
        break;
      end
      step(1'b0, 1'b1);
    end
    check("reach_target", {10'd0, reached}, 11'd1);
  endtask

  initial begin
    logic [7:0] cap;
    rst_n        = 1'b0;
    pass_request = 1'b0;
    model_update(1'b0, 1'b0);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    check("reset_state", obs_word, exp_q.pop_front());
    check("reset_const", obs_word, word(1, 0, 0, 10));

    // Edges 15..35: red counting down from 10.
    steps(3, 1'b0);
    check("red_t40", obs_word, word(1, 0, 0, 7));

    // Edges 45..135: green entered at 105.
    steps(10, 1'b0);
    check("green_t140", obs_word, word(0, 0, 1, 57));

    cap = clock;
    steps(3, 1'b0);
    check("count_down3", {3'd0, clock}, {3'd0, cap - 8'd3});

    // Through edge 735: yellow entered at 705.
    steps(57, 1'b0);
    check("yellow_t740", obs_word, word(0, 1, 0, 2));

    // Through edge 915: back in green at 855.
    steps(18, 1'b0);
    check("green_t920", obs_word, word(0, 0, 1, 54));

    step(1'b1, 1'b1);
    check("pass_load", obs_word, word(0, 0, 1, 10));
    steps(10, 1'b0);
    check("pass_to_yellow", obs_word, word(0, 1, 0, 5));

    // Request below PASS_TIME is ignored; hold it across yellow and red.
    run_until(1, 9, 300);
    step(1'b0, 1'b1);
    steps(3, 1'b1);
    check("low_pass_ignored", obs_word, word(0, 0, 1, 5));
    steps(5, 1'b1);
    check("held_yellow", obs_word, word(0, 1, 0, 5));
    steps(5, 1'b1);
    check("held_red", obs_word, word(1, 0, 0, 10));
    steps(10, 1'b1);
    check("held_green_entry", obs_word, word(0, 0, 1, 60));
    step(1'b1, 1'b1);
    check("held_pass_load", obs_word, word(0, 0, 1, 10));
    step(1'b1, 1'b1);
    check("pass_at_limit", obs_word, word(0, 0, 1, 9));
    step(1'b0, 1'b1);

    // Boundary: clock = PASS_TIME+1 still triggers a reload.
    run_until(2, 1, 300);
    run_until(1, 11, 300);
    step(1'b1, 1'b1);
    check("pass_at_11", obs_word, word(0, 0, 1, 10));

    // Reset asserted mid-phase wins over counting.
    steps(3, 1'b0);
    step(1'b0, 1'b0);
    check("mid_reset", obs_word, word(1, 0, 0, 10));
    steps(4, 1'b0);
    check("after_mid_reset", obs_word, word(1, 0, 0, 6));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/traffic_light.md
Name: traffic_light

Overview:
- Single-road traffic-light sequencer with a pedestrian pass request.
- Cycles RED -> GREEN -> YELLOW -> RED with fixed per-phase durations counted in clk cycles.
- Exposes the remaining time of the current phase on `clock`.
- A pedestrian `pass_request` during GREEN shortens the remaining green time. Sits as a leaf controller driving lamp outputs.

Parameters:
- RED_TIME, 10, RED phase duration in cycles (1..255)
- GREEN_TIME, 60, GREEN phase duration in cycles (1..255)
- YELLOW_TIME, 5, YELLOW phase duration in cycles (1..255)
- PASS_TIME, 10, remaining-green value forced by a pass request (1..255)

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous, active-low reset
- pass_request  input  1  pedestrian request, level-sampled each cycle
- clock  output  8  remaining cycles of the current phase, registered
- red  output  1  red lamp, registered
- yellow  output  1  yellow lamp, registered
- green  output  1  green lamp, registered

Behaviour:
- One clock (clk). Reset is synchronous and active-low (rst_n), sampled only on clk rising edge.
- Reset response: state=RED, clock=RED_TIME, red=1, yellow=0, green=0. Reset asserted mid-phase overrides everything on that edge.
- States are RED, GREEN and YELLOW; exactly one lamp is high at all times and it matches the state.
- Phase entry loads clock with the phase duration. Each following cycle clock decrements by 1.
- When clock==1, the next edge moves to the next phase and loads that phase's duration:
  - RED -> GREEN (load GREEN_TIME)
  - GREEN -> YELLOW (load YELLOW_TIME)
  - YELLOW -> RED (load RED_TIME)
- Each phase therefore lasts exactly its duration. clock shows N..1 and never shows 0 after reset.
- Lamp outputs change on the same edge as the clock reload; there is no extra latency.
- Pass request: in GREEN, if pass_request==1 and clock>PASS_TIME, the next edge loads clock=PASS_TIME (green stays on). Counting then continues normally.
- In GREEN with clock<=PASS_TIME, pass_request has no effect and the normal decrement/transition applies.
- pass_request is ignored in RED and YELLOW.
- A held pass_request re-applies only while clock>PASS_TIME, so a sustained request cannot extend green.
- Arithmetic is 8-bit unsigned; no wrap-around is reachable because reload happens at 1.
- Timing at reset release: rst_n low through the edge at t=5 ns (10 ns period), high from t=10 ns.
  - RED holds clock 10..1 on edges 5..95 ns.
  - GREEN starts at the 105 ns edge; YELLOW at 705 ns; RED at 755 ns; GREEN at 855 ns.

Optional Feature:
- Macro: TRAFFIC_LIGHT_PASS_LATCH_EN.
- Defined: a pass_request seen in RED or YELLOW sets an internal pending flag. On entry to GREEN the loaded value is PASS_TIME instead of GREEN_TIME, and the flag clears. Reset clears the flag.
- Not defined: no pending flag; requests outside GREEN are discarded as described above.

Test Plan:
- Reset for 1 cycle, sample 30 ns after release -> red=1, yellow=0, green=0, clock counting down from 10.
- Sample 100 ns later (t=140 ns) -> green=1, red=0, yellow=0, clock near 57.
- Sample 600 ns later (t=740 ns) -> yellow=1, red=0, green=0.
- No request: capture clock during GREEN, wait 3 cycles -> clock equals the captured value minus 3 (not plus 3).
- At t=920 ns in GREEN (clock=54), assert pass_request -> after one edge clock=10, green=1. Then 10 more cycles -> yellow=1, clock=5.
- In GREEN with clock=8, assert pass_request -> clock continues 7, 6, …; pass_request held during RED/YELLOW -> no effect (macro off).
